// File: rtl/frame_config_pkg.sv
// Shared constants for the frame configuration loader: FSM encodings,
// header bit-field positions and the default sync word.
package frame_config_pkg;

    typedef logic [1:0] state_t;

    localparam state_t UNSYNC = 2'd0;
    localparam state_t HEADER = 2'd1;
    localparam state_t DATA   = 2'd2;

    localparam int DESYNC_BIT = 31;
    localparam int COL_MSB    = 23;
    localparam int COL_LSB    = 16;
    localparam int FRAME_MSB  = 4;
    localparam int FRAME_LSB  = 0;

    localparam int COL_W   = COL_MSB - COL_LSB + 1;
    localparam int FRAME_W = FRAME_MSB - FRAME_LSB + 1;

    localparam logic [31:0] SYNC_WORD_DEFAULT = 32'hFAB0_FAB1;

endpackage

// File: rtl/frame_strobe_decoder.sv
// Turns a latched (column, frame) address into a registered one-hot
// FrameStrobe pulse; addresses outside the array never match any bit.
module frame_strobe_decoder
    import frame_config_pkg::*;
#(
    parameter int NumberOfCols    = 16,
    parameter int MaxFramesPerCol = 20
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic [COL_W-1:0]                        col,
    input  logic [FRAME_W-1:0]                      frame,
    input  logic                                    valid,
    input  logic                                    fire,
    output logic [NumberOfCols*MaxFramesPerCol-1:0] strobe
);

    logic [NumberOfCols*MaxFramesPerCol-1:0] hit;

    always_comb begin
        hit = '0;
        for (int c = 0; c < NumberOfCols; c++) begin
            for (int f = 0; f < MaxFramesPerCol; f++) begin
                hit[c*MaxFramesPerCol+f] = (col == COL_W'(c)) && (frame == FRAME_W'(f));
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            strobe <= '0;
        end else begin
            strobe <= (fire && valid) ? hit : '0;
        end
    end

endmodule

// File: rtl/frame_config_loader.sv
// Bitstream front-end: finds the sync word, decodes frame headers, shifts
// row data into FrameData and fires one FrameStrobe per complete packet.
module frame_config_loader
    import frame_config_pkg::*;
#(
    parameter int                          FrameBitsPerRow = 32,
    parameter int                          MaxFramesPerCol = 20,
    parameter int                          NumberOfRows    = 16,
    parameter int                          NumberOfCols    = 16,
    parameter logic [FrameBitsPerRow-1:0]  SyncWord        = SYNC_WORD_DEFAULT
) (
    input  logic                                     CLK,
    input  logic                                     reset,
    input  logic [FrameBitsPerRow-1:0]               WriteData,
    input  logic                                     WriteStrobe,
    output logic [NumberOfRows*FrameBitsPerRow-1:0]  FrameData,
    output logic [NumberOfCols*MaxFramesPerCol-1:0]  FrameStrobe,
    output logic                                     Synced,
    output logic                                     FrameError,
    output logic [15:0]                              FramesWritten
);

    localparam int ROW_W = (NumberOfRows > 1) ? $clog2(NumberOfRows) : 1;

    state_t              state;
    logic [ROW_W-1:0]    row_cnt;
    logic [COL_W-1:0]    col_q;
    logic [FRAME_W-1:0]  frame_q;
    logic                addr_valid_q;
    logic                fire_q;

    logic                is_sync;
    logic                hdr_desync;
    logic [COL_W-1:0]    hdr_col;
    logic [FRAME_W-1:0]  hdr_frame;
    logic                hdr_valid;
    logic                last_word;

    assign is_sync    = (WriteData == SyncWord);
    assign hdr_desync = WriteData[DESYNC_BIT];
    assign hdr_col    = WriteData[COL_MSB:COL_LSB];
    assign hdr_frame  = WriteData[FRAME_MSB:FRAME_LSB];
    assign hdr_valid  = (hdr_col < COL_W'(NumberOfCols)) && (hdr_frame < FRAME_W'(MaxFramesPerCol));
    assign last_word  = (row_cnt == ROW_W'(NumberOfRows - 1));
    assign Synced     = (state == HEADER) || (state == DATA);

    // fire_q marks the cycle after the last data word; the decoder registers
    // it once more, so the strobe trails the final FrameData update by a cycle.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state        <= UNSYNC;
            row_cnt      <= '0;
            col_q        <= '0;
            frame_q      <= '0;
            addr_valid_q <= 1'b0;
            fire_q       <= 1'b0;
            FrameError   <= 1'b0;
            FrameData    <= '0;
        end else begin
            fire_q <= 1'b0;
            if (WriteStrobe) begin
                case (state)
                    UNSYNC: begin
                        if (is_sync) begin
                            state      <= HEADER;
                            FrameError <= 1'b0;
                        end
                    end
                    HEADER: begin
                        if (is_sync) begin
                            state <= HEADER;
                        end else if (hdr_desync) begin
                            state <= UNSYNC;
                        end else begin
                            // Bad addresses still consume the data words to keep packets aligned.
                            col_q        <= hdr_col;
                            frame_q      <= hdr_frame;
                            addr_valid_q <= hdr_valid;
                            row_cnt      <= '0;
                            state        <= DATA;
                            if (!hdr_valid) begin
                                FrameError <= 1'b1;
                            end
                        end
                    end
                    DATA: begin
                        for (int r = 0; r < NumberOfRows; r++) begin
                            if (row_cnt == ROW_W'(r)) begin
                                FrameData[r*FrameBitsPerRow +: FrameBitsPerRow] <= WriteData;
                            end
                        end
                        if (last_word) begin
                            state  <= HEADER;
                            fire_q <= 1'b1;
                        end else begin
                            row_cnt <= row_cnt + ROW_W'(1);
                        end
                    end
                    default: state <= UNSYNC;
                endcase
            end
        end
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            FramesWritten <= '0;
        end else if (fire_q && addr_valid_q && (FramesWritten != 16'hFFFF)) begin
            FramesWritten <= FramesWritten + 16'd1;
        end
    end

    frame_strobe_decoder #(
        .NumberOfCols    (NumberOfCols),
        .MaxFramesPerCol (MaxFramesPerCol)
    ) u_strobe_decoder (
        .clk    (CLK),
        .rst    (reset),
        .col    (col_q),
        .frame  (frame_q),
        .valid  (addr_valid_q),
        .fire   (fire_q),
        .strobe (FrameStrobe)
    );

endmodule

// File: tb/tb_frame_config_loader.sv
// Directed bench for frame_config_loader: sync, packet decode, strobe
// timing, invalid addresses, desync and mid-packet reset.
module tb_frame_config_loader;
    import frame_config_pkg::*;

    localparam logic [31:0] SYNC = 32'hFAB0_FAB1;

    logic         CLK;
    logic         reset;
    logic [31:0]  WriteData;
    logic         WriteStrobe;
    logic [511:0] FrameData;
    logic [319:0] FrameStrobe;
    logic         Synced;
    logic         FrameError;
    logic [15:0]  FramesWritten;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0]  pkt_data [16];
    logic [511:0] exp_prev;

    frame_config_loader dut (
        .CLK           (CLK),
        .reset         (reset),
        .WriteData     (WriteData),
        .WriteStrobe   (WriteStrobe),
        .FrameData     (FrameData),
        .FrameStrobe   (FrameStrobe),
        .Synced        (Synced),
        .FrameError    (FrameError),
        .FramesWritten (FramesWritten)
    );

    // clock / reset
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [511:0] onehot(input int idx);
        logic [511:0] v;
        v = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    function automatic logic [511:0] exp_frame();
        logic [511:0] v;
        for (int r = 0; r < 16; r++) v[r*32 +: 32] = pkt_data[r];
        return v;
    endfunction

    // driver tasks
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send(input logic [31:0] w);
        WriteData   = w;
        WriteStrobe = 1'b1;
        @(posedge CLK);
        #1;
        WriteStrobe = 1'b0;
    endtask

    task automatic fill(input logic [31:0] base);
        for (int r = 0; r < 16; r++) pkt_data[r] = base + 32'(r);
    endtask

    task automatic send_data(input bit gap);
        for (int r = 0; r < 16; r++) begin
            send(pkt_data[r]);
            if (gap && r == 7) begin
                tick();
                tick();
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        WriteData = '0;
        WriteStrobe = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        check("rst_data", FrameData, '0);
        check("rst_strobe", 512'(FrameStrobe), '0);
        check("rst_synced", 512'(Synced), '0);
        check("rst_error", 512'(FrameError), '0);
        check("rst_count", 512'(FramesWritten), '0);
        check("rst_state", 512'(dut.state), 512'(UNSYNC));
        reset = 1'b0;
        tick();

        // pre-sync garbage, then sync (a second sync in HEADER is ignored)
        send(32'h1234_5678);
        check("presync_synced", 512'(Synced), '0);
        check("presync_state", 512'(dut.state), 512'(UNSYNC));
        send(SYNC);
        check("sync_synced", 512'(Synced), 512'(1));
        send(SYNC);
        check("sync_again_state", 512'(dut.state), 512'(HEADER));

        // packet col 3 frame 5, rows 0..15
        send(32'h0003_0005);
        fill(32'h0);
        send_data(1'b0);
        check("p1_data", FrameData, exp_frame());
        check("p1_strobe_n1", 512'(FrameStrobe), '0);
        tick();
        check("p1_strobe_n2", 512'(FrameStrobe), onehot(65));
        check("p1_count", 512'(FramesWritten), 512'(1));
        tick();
        check("p1_strobe_n3", 512'(FrameStrobe), '0);

        // back-to-back: (0,0) then (15,19), with a gap inside the second packet
        send(32'h0000_0000);
        fill(32'h100);
        send_data(1'b0);
        exp_prev = exp_frame();
        send(32'h000F_0013);
        check("b2b_strobe0", 512'(FrameStrobe), onehot(0));
        check("b2b_hold", FrameData, exp_prev);
        check("b2b_count0", 512'(FramesWritten), 512'(2));
        fill(32'h200);
        send_data(1'b1);
        check("b2b_data1", FrameData, exp_frame());
        check("b2b_strobe1_n1", 512'(FrameStrobe), '0);
        tick();
        check("b2b_strobe319", 512'(FrameStrobe), onehot(319));
        check("b2b_count1", 512'(FramesWritten), 512'(3));
        tick();
        check("b2b_strobe_off", 512'(FrameStrobe), '0);

        // invalid column 16 and invalid frame 20
        send(32'h0010_0000);
        check("badcol_error", 512'(FrameError), 512'(1));
        fill(32'h300);
        send_data(1'b0);
        check("badcol_n1", 512'(FrameStrobe), '0);
        tick();
        check("badcol_n2", 512'(FrameStrobe), '0);
        send(32'h0000_0014);
        fill(32'h310);
        send_data(1'b0);
        tick();
        check("badfrm_n2", 512'(FrameStrobe), '0);
        check("bad_count", 512'(FramesWritten), 512'(3));
        send(32'h0001_0002);
        fill(32'h320);
        send_data(1'b0);
        tick();
        check("after_bad_strobe", 512'(FrameStrobe), onehot(22));
        check("after_bad_count", 512'(FramesWritten), 512'(4));
        check("after_bad_error", 512'(FrameError), 512'(1));

        // desync, then a would-be packet is discarded
        send(32'h8000_0000);
        check("desync_synced", 512'(Synced), '0);
        send(32'h0001_0001);
        fill(32'h330);
        send_data(1'b0);
        tick();
        check("desync_strobe", 512'(FrameStrobe), '0);
        check("desync_count", 512'(FramesWritten), 512'(4));
        check("desync_error_held", 512'(FrameError), 512'(1));
        send(SYNC);
        check("resync_error_clr", 512'(FrameError), '0);
        check("resync_synced", 512'(Synced), 512'(1));

        // reset after 7 data words aborts the packet
        send(32'h0002_0003);
        fill(32'h400);
        for (int r = 0; r < 7; r++) send(pkt_data[r]);
        reset = 1'b1;
        #1;
        check("midrst_data", FrameData, '0);
        check("midrst_strobe", 512'(FrameStrobe), '0);
        check("midrst_count", 512'(FramesWritten), '0);
        check("midrst_synced", 512'(Synced), '0);
        check("midrst_state", 512'(dut.state), 512'(UNSYNC));
        tick();
        reset = 1'b0;
        tick();
        tick();
        check("midrst_no_strobe", 512'(FrameStrobe), '0);

        // resync and full packet; a data word equal to the sync word is just data
        send(SYNC);
        send(32'h0002_0003);
        fill(32'h500);
        pkt_data[4] = SYNC;
        send_data(1'b0);
        check("final_data", FrameData, exp_frame());
        tick();
        check("final_strobe", 512'(FrameStrobe), onehot(43));
        check("final_count", 512'(FramesWritten), 512'(1));
        check("final_state", 512'(dut.state), 512'(HEADER));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
